// File: rtl/move_controller.sv
// Board move controller: select a source piece of the side to move, then a destination, and commit the move.
// Move commit takes 4 cycles after the destination select; selects arriving while busy are dropped.
module move_controller #(
  parameter int SQ_W = 6,
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [SQ_W-1:0] cursor_sq,
  input  logic            select_pulse,
  input  logic [PC_W-1:0] mem_rdata,
  output logic [SQ_W-1:0] mem_addr,
  output logic            mem_we,
  output logic [PC_W-1:0] mem_wdata,
  output logic            turn,
  output logic            src_valid,
  output logic [SQ_W-1:0] src_sq,
  output logic            busy,
  output logic            move_done,
  output logic            sel_error
);

  typedef enum logic [2:0] {
    SRC_WAIT,
    SRC_READ,
    SRC_CHK,
    DST_WAIT,
    DST_READ,
    DST_CHK,
    WR_DST,
    WR_SRC
  } state_t;

  state_t          state_q, state_d;
  logic            turn_q, turn_d;
  logic            src_valid_q, src_valid_d;
  logic [SQ_W-1:0] src_sq_q, src_sq_d;
  logic [SQ_W-1:0] dst_sq_q, dst_sq_d;
  logic [PC_W-1:0] src_pc_q, src_pc_d;
  logic            src_ok, dst_ok;

  // The top piece-code bit is the colour; an all-zero code is an empty square.
  assign src_ok = (mem_rdata != '0) && (mem_rdata[PC_W-1] == turn_q);
  assign dst_ok = (mem_rdata == '0) || (mem_rdata[PC_W-1] != turn_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= SRC_WAIT;
      turn_q      <= 1'b0;
      src_valid_q <= 1'b0;
      src_sq_q    <= '0;
      dst_sq_q    <= '0;
      src_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      turn_q      <= turn_d;
      src_valid_q <= src_valid_d;
      src_sq_q    <= src_sq_d;
      dst_sq_q    <= dst_sq_d;
      src_pc_q    <= src_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    turn_d      = turn_q;
    src_valid_d = src_valid_q;
    src_sq_d    = src_sq_q;
    dst_sq_d    = dst_sq_q;
    src_pc_d    = src_pc_q;
    mem_addr    = cursor_sq;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    busy        = 1'b1;
    move_done   = 1'b0;
    sel_error   = 1'b0;

    case (state_q)
      SRC_WAIT: begin
        busy = 1'b0;
        if (select_pulse) begin
          src_sq_d = cursor_sq;
          state_d  = SRC_READ;
        end
      end
      SRC_READ: begin
        mem_addr = src_sq_q;
        state_d  = SRC_CHK;
      end
      SRC_CHK: begin
        mem_addr = src_sq_q;
        if (src_ok) begin
          src_pc_d    = mem_rdata;
          src_valid_d = 1'b1;
          state_d     = DST_WAIT;
        end else begin
          sel_error = 1'b1;
          state_d   = SRC_WAIT;
        end
      end
      DST_WAIT: begin
        busy = 1'b0;
        if (select_pulse) begin
          // Re-selecting the held square drops the selection silently.
          if (cursor_sq == src_sq_q) begin
            src_valid_d = 1'b0;
            state_d     = SRC_WAIT;
          end else begin
            dst_sq_d = cursor_sq;
            state_d  = DST_READ;
          end
        end
      end
      DST_READ: begin
        mem_addr = dst_sq_q;
        state_d  = DST_CHK;
      end
      DST_CHK: begin
        mem_addr = dst_sq_q;
        if (dst_ok) begin
          state_d = WR_DST;
        end else begin
          sel_error = 1'b1;
          state_d   = DST_WAIT;
        end
      end
      WR_DST: begin
        mem_we    = 1'b1;
        mem_addr  = dst_sq_q;
        mem_wdata = src_pc_q;
        state_d   = WR_SRC;
      end
      WR_SRC: begin
        mem_we      = 1'b1;
        mem_addr    = src_sq_q;
        move_done   = 1'b1;
        turn_d      = ~turn_q;
        src_valid_d = 1'b0;
        state_d     = SRC_WAIT;
      end
      default: state_d = SRC_WAIT;
    endcase
  end

  assign turn      = turn_q;
  assign src_valid = src_valid_q;
  assign src_sq    = src_sq_q;

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: board memory, transaction-level reference model, directed and random selects.
module tb_move_controller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] cursor_sq = '0;
  logic       select_pulse = 1'b0;
  logic [3:0] mem_rdata;
  logic [5:0] mem_addr;
  logic       mem_we;
  logic [3:0] mem_wdata;
  logic       turn, src_valid, busy, move_done, sel_error;
  logic [5:0] src_sq;

  move_controller #(.SQ_W(6), .PC_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .cursor_sq(cursor_sq), .select_pulse(select_pulse),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .turn(turn), .src_valid(src_valid), .src_sq(src_sq), .busy(busy),
    .move_done(move_done), .sel_error(sel_error)
  );

  always #5 clk = ~clk;

  // Board memory with one-cycle read latency and a bench-side preload port.
  logic [3:0] board [64];
  logic       pl_we = 1'b0;
  logic [5:0] pl_addr = '0;
  logic [3:0] pl_data = '0;
  initial mem_rdata = '0;
  always @(posedge clk) begin
    mem_rdata <= board[mem_addr];
    if (pl_we) board[pl_addr] <= pl_data;
    else if (mem_we) board[mem_addr] <= mem_wdata;
  end

  typedef struct packed {
    logic       busy;
    logic       we;
    logic [5:0] addr;
    logic [3:0] wdata;
    logic       done;
    logic       err;
    logic       turn;
    logic       sv;
    logic [5:0] ssq;
  } exp_t;

  // Reference model: what the controller has committed to, plus a queue of busy-cycle outputs.
  logic [3:0] ref_board [64];
  logic       m_turn = 1'b0, m_sv = 1'b0;
  logic [5:0] m_ssq = '0;
  logic [3:0] m_spc = '0;
  exp_t       q [$];
  logic       chk_en = 1'b0;
  int         n_tests = 0, n_fail = 0, cyc = 0;

  function automatic exp_t mk(logic b, logic we, logic [5:0] a, logic [3:0] wd,
                              logic d, logic e, logic t, logic sv, logic [5:0] s);
    exp_t r;
    r.busy = b; r.we = we; r.addr = a; r.wdata = wd; r.done = d;
    r.err = e; r.turn = t; r.sv = sv; r.ssq = s;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic model_select(input logic [5:0] c);
    logic [3:0] pc;
    exp_t r;
    if (!m_sv) begin
      pc = ref_board[c];
      r = mk(1, 0, c, 0, 0, 0, m_turn, 0, c);
      q.push_back(r);
      r.err = !(pc != 0 && pc[3] == m_turn);
      q.push_back(r);
      m_ssq = c;
      if (!r.err) begin m_sv = 1'b1; m_spc = pc; end
    end else if (c == m_ssq) begin
      m_sv = 1'b0;
    end else begin
      pc = ref_board[c];
      r = mk(1, 0, c, 0, 0, 0, m_turn, 1, m_ssq);
      q.push_back(r);
      r.err = !(pc == 0 || pc[3] != m_turn);
      q.push_back(r);
      if (!r.err) begin
        q.push_back(mk(1, 1, c, m_spc, 0, 0, m_turn, 1, m_ssq));
        q.push_back(mk(1, 1, m_ssq, 4'h0, 1, 0, m_turn, 1, m_ssq));
        m_turn = ~m_turn;
        m_sv   = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive inputs after the edge, compare at the falling edge, then advance the model.
  task automatic step(input logic [5:0] cur, input logic sel, input logic rst);
    exp_t e, a;
    logic idle;
    @(posedge clk);
    #1;
    cursor_sq = cur; select_pulse = sel; reset_n = ~rst;
    @(negedge clk);
    cyc++;
    idle = (q.size() == 0);
    e = idle ? mk(0, 0, cur, 0, 0, 0, m_turn, m_sv, m_ssq) : q.pop_front();
    if (!e.we) e.wdata = '0;
    a = {busy, mem_we, mem_addr, (e.we ? mem_wdata : 4'h0), move_done, sel_error,
         turn, src_valid, src_sq};
    if (chk_en) begin
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle %0d outputs {busy,we,addr,wdata,done,err,turn,sv,ssq}: got %h, required %h",
                 cyc, a, e);
      end
    end
    if (e.we) ref_board[e.addr] = e.wdata;
    if (rst) begin
      m_turn = 0; m_sv = 0; m_ssq = 0; m_spc = 0;
      q.delete();
      chk_en = 1'b1;
    end else if (idle && sel) begin
      model_select(cur);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [3:0] d, input logic rst);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    ref_board[a] = d;
    step(6'd63, 0, rst);
    pl_we = 1'b0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(6'd0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_board[i] = '0;
    step(0, 0, 1);
    step(0, 0, 1);
    for (int i = 0; i < 64; i++) preload(i[5:0], 4'h0, 1);
    preload(12, 4'h1, 1);
    preload(52, 4'h9, 1);
    preload(44, 4'h3, 1);
    step(5, 0, 0);
    chk("reset_turn", turn, 0);
    chk("reset_src_valid", src_valid, 0);
    chk("reset_src_sq", src_sq, 0);
    chk("idle_addr_follows_cursor", mem_addr, 5);

    // Wrong colour at turn 0.
    step(52, 1, 0); step(0, 0, 0); step(0, 0, 0);
    chk("wrong_colour_sel_error", sel_error, 1);
    step(0, 0, 0);
    chk("wrong_colour_src_valid", src_valid, 0);
    chk("wrong_colour_idle", busy, 0);

    // Cancel by reselecting the source.
    step(12, 1, 0); idle_n(3);
    chk("cancel_src_held", src_valid, 1);
    step(12, 1, 0); step(0, 0, 0);
    chk("cancel_src_valid", src_valid, 0);
    chk("cancel_turn", turn, 0);

    // White move 12 -> 28.
    step(12, 1, 0); idle_n(3);
    step(28, 1, 0); idle_n(3);
    chk("white_wr_dst_addr", mem_addr, 28);
    chk("white_wr_dst_data", mem_wdata, 1);
    step(0, 0, 0);
    chk("white_move_done_cycle4", move_done, 1);
    chk("white_wr_src_addr", mem_addr, 12);
    step(0, 0, 0);
    chk("white_turn_after", turn, 1);
    chk("white_board28", board[28], 1);
    chk("white_board12", board[12], 0);

    // Black capture 52 -> 44 with a select injected while busy.
    step(52, 1, 0); idle_n(3);
    step(44, 1, 0); step(0, 0, 0); step(60, 1, 0); idle_n(3);
    chk("capture_turn_after", turn, 0);
    chk("capture_board44", board[44], 9);
    chk("capture_board52", board[52], 0);
    chk("busy_select_ignored", src_valid, 0);

    // Own-piece destination, then a legal one.
    preload(12, 4'h1, 0);
    preload(13, 4'h2, 0);
    step(12, 1, 0); idle_n(3);
    step(13, 1, 0); step(0, 0, 0); step(0, 0, 0);
    chk("own_piece_sel_error", sel_error, 1);
    step(0, 0, 0);
    chk("own_piece_src_kept", src_valid, 1);
    chk("own_piece_board13", board[13], 2);
    step(20, 1, 0); idle_n(6);
    chk("own_piece_retry_board20", board[20], 1);
    chk("own_piece_retry_turn", turn, 1);

    // Reset during WR_DST aborts the source clear.
    preload(52, 4'h9, 0);
    step(52, 1, 0); idle_n(3);
    step(40, 1, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 1);
    step(0, 0, 0);
    chk("reset_mid_turn", turn, 0);
    chk("reset_mid_src_valid", src_valid, 0);
    chk("reset_mid_idle", busy, 0);
    step(0, 0, 0);
    chk("reset_mid_board52", board[52], 9);

    // Random phase.
    for (int i = 0; i < 64; i++) begin
      logic [3:0] pc;
      pc = ($urandom_range(0, 1) == 0) ? 4'h0 : {$urandom_range(0, 1) == 1, 3'($urandom_range(1, 6))};
      preload(i[5:0], pc, 1);
    end
    for (int i = 0; i < 4000; i++) begin
      step(6'($urandom_range(0, 15)), $urandom_range(0, 2) == 0, $urandom_range(0, 499) == 0);
    end
    idle_n(6);
    for (int i = 0; i < 64; i++) chk("final_board", board[i], ref_board[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/move_controller.md
MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 Parameter SQ_W, default 6, square index width (64 squares, index = row*8 + col).
REQ-002 Parameter PC_W, default 4, piece code width: bit 3 is colour (0 white, 1 black), bits 2:0 are type, and code 0 means an empty square.
REQ-003 clk  input  1  system clock; every register updates on the rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 cursor_sq  input  SQ_W  current cursor square.
REQ-006 select_pulse  input  1  one-cycle pulse from the debounced select key.
REQ-007 mem_rdata  input  PC_W  board memory read data, valid one cycle after mem_addr is presented.
REQ-008 mem_addr  output  SQ_W  board memory address (combinational from state and registers).
REQ-009 mem_we  output  1  board memory write enable.
REQ-010 mem_wdata  output  PC_W  board memory write data.
REQ-011 turn  output  1  side to move: 0 white, 1 black.
REQ-012 src_valid  output  1  high while a source square is held.
REQ-013 src_sq  output  SQ_W  held source square, used by the display for highlighting.
REQ-014 busy  output  1  high in every state except SRC_WAIT and DST_WAIT.
REQ-015 move_done  output  1  one-cycle pulse when a move commits.
REQ-016 sel_error  output  1  one-cycle pulse when a selection is rejected.

Function
REQ-017 The FSM SHALL have exactly these states: SRC_WAIT, SRC_READ, SRC_CHK, DST_WAIT, DST_READ, DST_CHK, WR_DST, WR_SRC.
REQ-018 In SRC_WAIT, a select_pulse SHALL latch cursor_sq into src_sq and move the FSM to SRC_READ.
REQ-019 In SRC_READ, mem_addr SHALL equal src_sq, mem_we SHALL be 0, and the next state is SRC_CHK.
REQ-020 SRC_CHK accept condition:
- mem_rdata is not 0 and mem_rdata[3] equals turn.
- On accept: latch mem_rdata into src_pc, set src_valid=1, go to DST_WAIT.
- Otherwise: pulse sel_error and return to SRC_WAIT.
REQ-021 In DST_WAIT, a select_pulse with cursor_sq equal to src_sq SHALL cancel: clear src_valid and return to SRC_WAIT, with no sel_error.
REQ-022 In DST_WAIT, any other select_pulse SHALL latch cursor_sq into dst_sq and move the FSM to DST_READ, where mem_addr equals dst_sq.
REQ-023 DST_CHK accept condition:
- mem_rdata is 0 (empty), or mem_rdata[3] differs from turn (capture).
- On accept: go to WR_DST.
- Otherwise (own piece): pulse sel_error, stay source-selected, return to DST_WAIT.
REQ-024 In WR_DST, mem_we=1, mem_addr=dst_sq and mem_wdata=src_pc.
REQ-025 In WR_SRC:
- mem_we=1, mem_addr=src_sq, mem_wdata=0.
- move_done pulses high.
- On exit: turn toggles, src_valid clears, next state is SRC_WAIT.
REQ-026 Latency from an accepted destination select_pulse (cycle 0) SHALL be:
- DST_READ at cycle 1, DST_CHK at cycle 2, WR_DST at cycle 3, WR_SRC and move_done at cycle 4.
- turn updated and SRC_WAIT at cycle 5.
REQ-027 A select_pulse received while busy=1 SHALL be ignored, not queued.
REQ-028 mem_we SHALL be 0 in every state other than WR_DST and WR_SRC.
REQ-029 In idle states mem_addr SHALL equal cursor_sq, so the display can read the square under the cursor.
REQ-030 The controller checks only colour and occupancy, not piece-movement rules.

Reset
REQ-031 While reset_n=0 on a rising edge, the following SHALL be cleared:
- state=SRC_WAIT.
- turn=0.
- src_valid=0, src_sq=0, src_pc=0, dst_sq=0.
- move_done=0, sel_error=0.
REQ-032 Reset asserted in WR_DST SHALL abort the move before WR_SRC; no further write occurs after the reset edge.
REQ-033 Reset has priority over a select_pulse in the same cycle.

Verification
REQ-034 White move: turn=0, square 12 holds 0x1, square 28 holds 0, select at 12 then at 28.
- Writes are (28,0x1) then (12,0x0).
- move_done fires at cycle 4 after the destination select.
- turn becomes 1.
REQ-035 Wrong colour: turn=0, square 52 holds 0x9, select at 52.
- sel_error pulses.
- src_valid stays 0, no write occurs, state returns to SRC_WAIT.
REQ-036 Own-piece destination: source 12 (0x1), destination 13 holding 0x2.
- sel_error pulses, state returns to DST_WAIT.
- src_valid stays 1, no writes occur.
- A following select at 20 (empty) completes the move.
REQ-037 Cancel: source 12 selected, then select at 12 again.
- src_valid=0, no sel_error, no writes, turn unchanged.
REQ-038 Capture plus busy: turn=1, source 52 (0x9), destination 44 holding 0x3.
- Writes are (44,0x9) then (52,0).
- A select_pulse injected at cycle 2 is ignored.
- turn becomes 0.
REQ-039 Reset mid-move: reset_n=0 in the WR_DST cycle.
- Square 52 is never cleared.
- Next cycle: turn=0, src_valid=0, state=SRC_WAIT.
